// File: rtl/counter_axil_pkg.sv
// Shared register map, response code and handshake FSM state types for the
// counter AXI4-Lite register block.
package counter_axil_pkg;

   localparam logic [31:0] REG_CTRL_OFF   = 32'h0;
   localparam logic [31:0] REG_START_OFF  = 32'h4;
   localparam logic [31:0] REG_COUNT_OFF  = 32'h8;
   localparam logic [31:0] REG_STATUS_OFF = 32'hC;

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_DIR_BIT = 1;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_RESP = 1'b1
   } w_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_e;

endpackage

// File: rtl/counter_axil_regs_wrap_detect.sv
// Flags a counter wrap: the count jumped between 0xFF and 0x00 in either
// direction since the previous clock edge.
module counter_wrap_detect (
   input  logic       aclk,
   input  logic       aresetn,
   input  logic [7:0] count,
   output logic       wrap_pulse
);

   logic [7:0] count_q;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the values from before the edge.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         count_q <= 8'h00;
      end else begin
         count_q <= count;
      end
   end

   assign wrap_pulse = ((count_q == 8'hFF) && (count == 8'h00)) ||
                       ((count_q == 8'h00) && (count == 8'hFF));

endmodule

// File: rtl/counter_axil_regs.sv
// AXI4-Lite slave holding the control and start value of an external 8-bit
// counter stage, exposing its live count and a sticky wrap flag.
module counter_axil_regs
   import counter_axil_pkg::*;
#(
   parameter int C_ADDR_WIDTH = 4,
   parameter int C_DATA_WIDTH = 32
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                      s_axi_awvalid,
   output logic                      s_axi_awready,
   input  logic [C_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                      s_axi_wvalid,
   output logic                      s_axi_wready,
   output logic [1:0]                s_axi_bresp,
   output logic                      s_axi_bvalid,
   input  logic                      s_axi_bready,
   input  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                      s_axi_arvalid,
   output logic                      s_axi_arready,
   output logic [C_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                s_axi_rresp,
   output logic                      s_axi_rvalid,
   input  logic                      s_axi_rready,
   output logic                      cnt_enable,
   output logic                      cnt_inc_dec,
   output logic [7:0]                cnt_start_value,
   input  logic [7:0]                cnt_count_in
);

   w_state_e                  w_state_q;
   r_state_e                  r_state_q;
   logic                      bvalid_q;
   logic                      arready_q;
   logic                      rvalid_q;
   logic [C_DATA_WIDTH-1:0]   rdata_q;
   logic [C_DATA_WIDTH-1:0]   rdata_d;
   logic                      en_q;
   logic                      dir_q;
   logic [7:0]                start_q;
   logic                      wrap_q;
   logic                      wrap_d;
   logic                      wrap_pulse;
   logic                      aw_w_hs;
   logic                      lane0_we;
   logic                      unused_bits;

   // Byte-lane offset bits are ignored; upper bits above the map must be zero.
   function automatic logic sel(input logic [C_ADDR_WIDTH-1:0] addr,
                                input logic [31:0]             off);
      return addr[C_ADDR_WIDTH-1:2] == off[C_ADDR_WIDTH-1:2];
   endfunction

   counter_wrap_detect u_wrap_detect (
      .aclk       (aclk),
      .aresetn    (aresetn),
      .count      (cnt_count_in),
      .wrap_pulse (wrap_pulse)
   );

   // Address and data are accepted together, and only while no response is pending.
   assign aw_w_hs  = aresetn && (w_state_q == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
   assign lane0_we = aw_w_hs && s_axi_wstrb[0];

   // A wrap arriving with a write-1-to-clear keeps the flag set.
   assign wrap_d = (wrap_q && !(lane0_we && sel(s_axi_awaddr, REG_STATUS_OFF) && s_axi_wdata[0]))
                   || wrap_pulse;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         w_state_q <= W_IDLE;
         bvalid_q  <= 1'b0;
         en_q      <= 1'b0;
         dir_q     <= 1'b0;
         start_q   <= 8'h00;
         wrap_q    <= 1'b0;
      end else begin
         case (w_state_q)
            W_IDLE: if (aw_w_hs) begin
               w_state_q <= W_RESP;
               bvalid_q  <= 1'b1;
            end
            W_RESP: if (s_axi_bready) begin
               w_state_q <= W_IDLE;
               bvalid_q  <= 1'b0;
            end
         endcase
         if (lane0_we && sel(s_axi_awaddr, REG_CTRL_OFF)) begin
            en_q  <= s_axi_wdata[CTRL_EN_BIT];
            dir_q <= s_axi_wdata[CTRL_DIR_BIT];
         end
         if (lane0_we && sel(s_axi_awaddr, REG_START_OFF)) begin
            start_q <= s_axi_wdata[7:0];
         end
         wrap_q <= wrap_d;
      end
   end

   // NOTE: the read mux assigns a default first so no path leaves rdata_d
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      rdata_d = '0;
      if (sel(s_axi_araddr, REG_CTRL_OFF)) begin
         rdata_d[CTRL_EN_BIT]  = en_q;
         rdata_d[CTRL_DIR_BIT] = dir_q;
      end else if (sel(s_axi_araddr, REG_START_OFF)) begin
         rdata_d[7:0] = start_q;
      end else if (sel(s_axi_araddr, REG_COUNT_OFF)) begin
         rdata_d[7:0] = cnt_count_in;
      end else if (sel(s_axi_araddr, REG_STATUS_OFF)) begin
         rdata_d[0] = wrap_q;
      end
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (arready_q && s_axi_arvalid) begin
                  r_state_q <= R_DATA;
                  arready_q <= 1'b0;
                  rvalid_q  <= 1'b1;
                  rdata_q   <= rdata_d;
               end
            end
            R_DATA: if (s_axi_rready) begin
               r_state_q <= R_IDLE;
               arready_q <= 1'b1;
               rvalid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign s_axi_awready   = aw_w_hs;
   assign s_axi_wready    = aw_w_hs;
   assign s_axi_bvalid    = bvalid_q;
   assign s_axi_bresp     = RESP_OKAY;
   assign s_axi_arready   = arready_q;
   assign s_axi_rvalid    = rvalid_q;
   assign s_axi_rdata     = rdata_q;
   assign s_axi_rresp     = RESP_OKAY;
   assign cnt_enable      = en_q;
   assign cnt_inc_dec     = dir_q;
   assign cnt_start_value = start_q;

   assign unused_bits = ^{s_axi_wdata[C_DATA_WIDTH-1:8], s_axi_wstrb[C_DATA_WIDTH/8-1:1],
                          s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_counter_axil_regs.sv
// Self-checking bench for counter_axil_regs: a register model predicts read
// data, queued at AR issue and compared when the R beat arrives.
module tb_counter_axil_regs;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [3:0]  s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [3:0]  s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic        cnt_enable;
   logic        cnt_inc_dec;
   logic [7:0]  cnt_start_value;
   logic [7:0]  cnt_count_in;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   logic        m_en;
   logic        m_dir;
   logic [7:0]  m_start;
   logic        m_wrap;

   always #5 aclk = ~aclk;

   counter_axil_regs #(.C_ADDR_WIDTH(4), .C_DATA_WIDTH(32)) dut (
      .aclk            (aclk),
      .aresetn         (aresetn),
      .s_axi_awaddr    (s_axi_awaddr),
      .s_axi_awvalid   (s_axi_awvalid),
      .s_axi_awready   (s_axi_awready),
      .s_axi_wdata     (s_axi_wdata),
      .s_axi_wstrb     (s_axi_wstrb),
      .s_axi_wvalid    (s_axi_wvalid),
      .s_axi_wready    (s_axi_wready),
      .s_axi_bresp     (s_axi_bresp),
      .s_axi_bvalid    (s_axi_bvalid),
      .s_axi_bready    (s_axi_bready),
      .s_axi_araddr    (s_axi_araddr),
      .s_axi_arvalid   (s_axi_arvalid),
      .s_axi_arready   (s_axi_arready),
      .s_axi_rdata     (s_axi_rdata),
      .s_axi_rresp     (s_axi_rresp),
      .s_axi_rvalid    (s_axi_rvalid),
      .s_axi_rready    (s_axi_rready),
      .cnt_enable      (cnt_enable),
      .cnt_inc_dec     (cnt_inc_dec),
      .cnt_start_value (cnt_start_value),
      .cnt_count_in    (cnt_count_in)
   );

   function automatic logic [31:0] model_read(input logic [3:0] addr);
      case (addr[3:2])
         2'd0:    return {30'b0, m_dir, m_en};
         2'd1:    return {24'b0, m_start};
         2'd2:    return {24'b0, cnt_count_in};
         default: return {31'b0, m_wrap};
      endcase
   endfunction

   task automatic model_write(input logic [3:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
      if (strb[0]) begin
         case (addr[3:2])
            2'd0:    begin m_en = data[0]; m_dir = data[1]; end
            2'd1:    m_start = data[7:0];
            2'd3:    if (data[0]) m_wrap = 1'b0;
            default: ;
         endcase
      end
   endtask

   task automatic model_reset();
      m_en = 1'b0; m_dir = 1'b0; m_start = 8'h00; m_wrap = 1'b0;
   endtask

   // Caller is positioned just after a rising edge.
   task automatic drive_aw_w(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
      s_axi_awaddr  = addr;
      s_axi_wdata   = data;
      s_axi_wstrb   = strb;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
   endtask

   task automatic wait_aw_w(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output int cycles);
      bit hs = 1'b0;
      cycles = 0;
      while (!hs && cycles < 20) begin
         @(negedge aclk);
         hs = s_axi_awready && s_axi_wready;
         @(posedge aclk);
         cycles++;
      end
      #1;
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      checks++;
      if (!hs) begin
         errors++;
         $display("FAIL aw_w_handshake addr %h: no awready/wready within %0d cycles", addr, cycles);
      end else begin
         model_write(addr, data, strb);
      end
   endtask

   task automatic wait_b();
      bit         got = 1'b0;
      int         n = 0;
      logic [1:0] resp = 2'b00;
      while (!got && n < 20) begin
         @(negedge aclk);
         if (s_axi_bvalid) begin
            got  = 1'b1;
            resp = s_axi_bresp;
         end
         @(posedge aclk);
         n++;
      end
      #1;
      checks++;
      if (!got || resp !== 2'b00) begin
         errors++;
         $display("FAIL b_response got valid=%0b resp=%b, expected valid=1 resp=00", got, resp);
      end
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
      int cyc;
      @(posedge aclk);
      #1;
      drive_aw_w(addr, data, strb);
      wait_aw_w(addr, data, strb, cyc);
      wait_b();
   endtask

   task automatic read_issue(input logic [3:0] addr);
      bit hs = 1'b0;
      int n = 0;
      exp_q.push_back(model_read(addr));
      @(posedge aclk);
      #1;
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      while (!hs && n < 20) begin
         @(negedge aclk);
         hs = s_axi_arready;
         @(posedge aclk);
         n++;
      end
      #1;
      s_axi_arvalid = 1'b0;
      checks++;
      if (!hs) begin
         errors++;
         $display("FAIL ar_handshake addr %h: arready not seen within %0d cycles", addr, n);
      end
   endtask

   task automatic collect_r(input string name);
      bit          got = 1'b0;
      int          n = 0;
      logic [31:0] data = '0;
      logic [31:0] exp;
      logic [1:0]  resp = 2'b00;
      while (!got && n < 20) begin
         @(negedge aclk);
         if (s_axi_rvalid) begin
            got  = 1'b1;
            data = s_axi_rdata;
            resp = s_axi_rresp;
         end
         @(posedge aclk);
         n++;
      end
      #1;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s: rvalid not seen within %0d cycles", name, n);
      end else if (data !== exp || resp !== 2'b00) begin
         errors++;
         $display("FAIL %s: rdata %h rresp %b, expected %h 00", name, data, resp, exp);
      end
   endtask

   task automatic axi_read(input logic [3:0] addr, input string name);
      read_issue(addr);
      collect_r(name);
   endtask

   task automatic test_reset();
      aresetn       = 1'b0;
      s_axi_awaddr  = '0; s_axi_awvalid = 1'b0;
      s_axi_wdata   = '0; s_axi_wstrb   = '0; s_axi_wvalid = 1'b0;
      s_axi_bready  = 1'b1;
      s_axi_araddr  = '0; s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b1;
      cnt_count_in  = 8'h00;
      model_reset();
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      checks++;
      if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid,
           cnt_enable, cnt_inc_dec, cnt_start_value, s_axi_bresp, s_axi_rresp,
           s_axi_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: bv=%b arr=%b rv=%b en=%b dir=%b start=%h rdata=%h, expected all 0",
                  s_axi_bvalid, s_axi_arready, s_axi_rvalid, cnt_enable, cnt_inc_dec,
                  cnt_start_value, s_axi_rdata);
      end
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      checks++;
      if (s_axi_arready !== 1'b1 || s_axi_bvalid !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: arready=%b bvalid=%b, expected 1 0", s_axi_arready, s_axi_bvalid);
      end
   endtask

   task automatic test_ctrl();
      int cyc;
      @(posedge aclk);
      #1;
      drive_aw_w(4'h0, 32'h0000_0003, 4'hF);
      wait_aw_w(4'h0, 32'h0000_0003, 4'hF, cyc);
      @(negedge aclk);
      checks++;
      if ({s_axi_bvalid, cnt_enable, cnt_inc_dec} !== {1'b1, m_en, m_dir}) begin
         errors++;
         $display("FAIL ctrl_after_hs: bvalid=%b en=%b dir=%b, expected 1 %b %b",
                  s_axi_bvalid, cnt_enable, cnt_inc_dec, m_en, m_dir);
      end
      @(posedge aclk);
      #1;
      @(negedge aclk);
      checks++;
      if (s_axi_bvalid !== 1'b0) begin
         errors++;
         $display("FAIL bvalid_clear: got %b expected 0", s_axi_bvalid);
      end
      axi_read(4'h0, "ctrl_read_3");
      axi_write(4'h0, 32'hFFFF_FFFF, 4'hF);
      axi_read(4'h0, "ctrl_unused_bits");
      axi_write(4'h0, 32'h0000_0002, 4'hF);
      @(negedge aclk);
      checks++;
      if ({cnt_enable, cnt_inc_dec} !== {m_en, m_dir}) begin
         errors++;
         $display("FAIL ctrl_outputs_2: en=%b dir=%b expected %b %b", cnt_enable, cnt_inc_dec, m_en, m_dir);
      end
      axi_write(4'h0, 32'h0000_0000, 4'hF);
   endtask

   task automatic test_start_strobe();
      axi_write(4'h4, 32'h0000_00A5, 4'b0000);
      axi_read(4'h4, "start_no_strobe");
      axi_write(4'h4, 32'h0000_00A5, 4'b0001);
      @(negedge aclk);
      checks++;
      if (cnt_start_value !== m_start) begin
         errors++;
         $display("FAIL start_output: got %h expected %h", cnt_start_value, m_start);
      end
      axi_write(4'h4, 32'h0000_005A, 4'b1110);
      axi_read(4'h4, "start_upper_lanes");
      axi_write(4'h8, 32'h0000_00FF, 4'hF);
      axi_read(4'h0, "count_write_ignored_ctrl");
      axi_read(4'h4, "count_write_ignored_start");
   endtask

   task automatic test_wrap();
      int cyc;
      @(posedge aclk); #1; cnt_count_in = 8'hFF;
      @(posedge aclk); #1; cnt_count_in = 8'h00;
      m_wrap = 1'b1;
      repeat (2) @(posedge aclk);
      axi_read(4'hC, "status_wrap_set");
      axi_write(4'hC, 32'h0000_0000, 4'hF);
      axi_read(4'hC, "status_write0_keeps");
      axi_write(4'hC, 32'h0000_0001, 4'hF);
      axi_read(4'hC, "status_w1c");
      @(posedge aclk);
      #1;
      cnt_count_in = 8'hFF;
      drive_aw_w(4'hC, 32'h0000_0001, 4'h1);
      wait_aw_w(4'hC, 32'h0000_0001, 4'h1, cyc);
      m_wrap = 1'b1;
      checks++;
      if (cyc != 1) begin
         errors++;
         $display("FAIL w1c_same_cycle_timing: handshake after %0d cycles, expected 1", cyc);
      end
      wait_b();
      axi_read(4'hC, "status_set_wins");
      axi_write(4'hC, 32'h0000_0001, 4'h1);
      axi_read(4'hC, "status_cleared_again");
   endtask

   task automatic test_back_to_back();
      int cyc;
      s_axi_bready = 1'b0;
      @(posedge aclk);
      #1;
      drive_aw_w(4'h0, 32'h0000_0001, 4'hF);
      wait_aw_w(4'h0, 32'h0000_0001, 4'hF, cyc);
      drive_aw_w(4'h4, 32'h0000_0011, 4'h1);
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         checks++;
         if ({s_axi_bvalid, s_axi_awready, s_axi_wready} !== 3'b100) begin
            errors++;
            $display("FAIL bp_hold_%0d: bvalid/awready/wready=%b expected 100", i,
                     {s_axi_bvalid, s_axi_awready, s_axi_wready});
         end
      end
      @(posedge aclk);
      #1;
      s_axi_bready = 1'b1;
      wait_aw_w(4'h4, 32'h0000_0011, 4'h1, cyc);
      checks++;
      if (cyc != 2) begin
         errors++;
         $display("FAIL bp_second_accept: accepted after %0d cycles, expected 2", cyc);
      end
      wait_b();
      @(negedge aclk);
      checks++;
      if ({cnt_enable, cnt_start_value} !== {m_en, m_start}) begin
         errors++;
         $display("FAIL bp_outputs: en=%b start=%h expected %b %h", cnt_enable, cnt_start_value, m_en, m_start);
      end
      axi_read(4'h4, "bp_start_read");
   endtask

   task automatic test_read_hold();
      logic [4:0] far_addr = 5'h10;
      axi_write(4'h0, 32'h0000_0000, 4'hF);
      @(posedge aclk);
      #1;
      cnt_count_in = 8'h3C;
      s_axi_rready = 1'b0;
      read_issue(4'h8);
      cnt_count_in = 8'h44;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         checks++;
         if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== exp_q[0]) begin
            errors++;
            $display("FAIL r_hold_%0d: rvalid=%b rdata=%h expected 1 %h", i, s_axi_rvalid, s_axi_rdata, exp_q[0]);
         end
      end
      @(posedge aclk);
      #1;
      s_axi_rready = 1'b1;
      collect_r("count_read_held");
      @(negedge aclk);
      checks++;
      if (s_axi_rvalid !== 1'b0) begin
         errors++;
         $display("FAIL rvalid_clear: got %b expected 0", s_axi_rvalid);
      end
      axi_read(far_addr[3:0], "addr_0x10_masked");
      axi_read(4'hB, "count_alias");
      axi_read(4'hD, "status_alias");
   endtask

   task automatic test_concurrent();
      fork
         axi_write(4'h4, 32'h0000_003C, 4'h1);
         axi_read(4'h0, "concurrent_ctrl_read");
      join
      axi_read(4'h4, "concurrent_start_read");
   endtask

   task automatic test_reset_in_flight();
      int cyc;
      axi_write(4'h0, 32'h0000_0003, 4'hF);
      axi_write(4'h4, 32'h0000_0077, 4'h1);
      s_axi_bready = 1'b0;
      @(posedge aclk);
      #1;
      drive_aw_w(4'h0, 32'h0000_0002, 4'hF);
      wait_aw_w(4'h0, 32'h0000_0002, 4'hF, cyc);
      @(negedge aclk);
      checks++;
      if (s_axi_bvalid !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_bvalid: got %b expected 1", s_axi_bvalid);
      end
      @(posedge aclk);
      #1;
      aresetn = 1'b0;
      model_reset();
      @(posedge aclk);
      @(negedge aclk);
      checks++;
      if ({s_axi_bvalid, cnt_enable, cnt_inc_dec, cnt_start_value} !== {1'b0, m_en, m_dir, m_start}) begin
         errors++;
         $display("FAIL rst_in_flight: bvalid=%b en=%b dir=%b start=%h expected all 0",
                  s_axi_bvalid, cnt_enable, cnt_inc_dec, cnt_start_value);
      end
      @(posedge aclk);
      #1;
      aresetn      = 1'b1;
      s_axi_bready = 1'b1;
      axi_write(4'h4, 32'h0000_005A, 4'h1);
      axi_read(4'h4, "post_reset_start");
      axi_read(4'h0, "post_reset_ctrl");
      axi_read(4'hC, "post_reset_status");
   endtask

   initial begin
      test_reset();
      test_ctrl();
      test_start_strobe();
      test_wrap();
      test_back_to_back();
      test_read_hold();
      test_concurrent();
      test_reset_in_flight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
